// File: rtl/decode_stage.sv
// Beta pipeline decode stage: IR/PC hold, 32-entry register file, N-source operand bypass,
// load-use interlock, decode-time branch resolution and exception/NOP injection.
module decode_stage #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     NBYP     = 3,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0]     NOP_INST = 32'h83FF_F800,
  parameter logic [31:0]     EXC_INST = 32'h77DF_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 if_valid,
  input  logic [31:0]          if_inst,
  input  logic [XLEN-1:0]      if_pc4,
  output logic                 dec_stall,
  input  logic                 flush,
  input  logic                 exc_req,
  input  logic [5*NBYP-1:0]    byp_rc,
  input  logic [NBYP-1:0]      byp_we,
  input  logic [NBYP-1:0]      byp_rdy,
  input  logic [XLEN*NBYP-1:0] byp_data,
  input  logic                 wb_we,
  input  logic [4:0]           wb_addr,
  input  logic [XLEN-1:0]      wb_data,
  output logic                 br_taken,
  output logic [XLEN-1:0]      br_target,
  output logic                 ex_valid,
  output logic [31:0]          ex_inst,
  output logic [XLEN-1:0]      ex_pc,
  output logic [XLEN-1:0]      ex_a,
  output logic [XLEN-1:0]      ex_b,
  output logic [XLEN-1:0]      ex_st
);

  localparam logic [5:0] OpLd  = 6'b011000;
  localparam logic [5:0] OpSt  = 6'b011001;
  localparam logic [5:0] OpJmp = 6'b011011;
  localparam logic [5:0] OpBeq = 6'b011100;
  localparam logic [5:0] OpBne = 6'b011101;
  localparam logic [5:0] OpLdr = 6'b011111;

  // Decode state
  logic [31:0]     ir_q, ir_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            valid_q, valid_d;

  // Execute pipeline register
  logic            ex_valid_q, ex_valid_d;
  logic [31:0]     ex_inst_q, ex_inst_d;
  logic [XLEN-1:0] ex_pc_q, ex_pc_d;
  logic [XLEN-1:0] ex_a_q, ex_a_d;
  logic [XLEN-1:0] ex_b_q, ex_b_d;
  logic [XLEN-1:0] ex_st_q, ex_st_d;

  logic [XLEN-1:0] rf_q [32];

  // Instruction fields
  logic [5:0]      op;
  logic [4:0]      rc, ra, rb, addr2;
  logic [XLEN-1:0] lit_sxt;

  logic is_ld, is_st, is_jmp, is_beq, is_bne, is_ldr, is_opc, is_op;
  logic use1, use2;

  logic [XLEN-1:0] rd1, rd2;
  logic            rdy1, rdy2;
  logic [XLEN:0]   port1, port2;
  logic [XLEN-1:0] branch_target;

  assign op      = ir_q[31:26];
  assign rc      = ir_q[25:21];
  assign ra      = ir_q[20:16];
  assign rb      = ir_q[15:11];
  assign lit_sxt = {{(XLEN-16){ir_q[15]}}, ir_q[15:0]};

  assign is_ld  = (op == OpLd);
  assign is_st  = (op == OpSt);
  assign is_jmp = (op == OpJmp);
  assign is_beq = (op == OpBeq);
  assign is_bne = (op == OpBne);
  assign is_ldr = (op == OpLdr);
  assign is_opc = (op[5:4] == 2'b11);
  // Undefined opcodes fall into OP so execute can raise the illegal-op trap.
  assign is_op  = !(is_ld || is_st || is_jmp || is_beq || is_bne || is_ldr || is_opc);

  assign use1  = !is_ldr;
  assign use2  = is_op || is_st;
  assign addr2 = is_st ? rc : rb;

  // Returns {ready, data}: youngest matching bypass, then WB write-through, then the array.
  function automatic logic [XLEN:0] read_port(input logic [4:0] addr);
    logic [XLEN-1:0] data;
    logic            rdy;
    logic            hit;
    data = (wb_we && (wb_addr == addr)) ? wb_data : rf_q[addr];
    rdy  = 1'b1;
    hit  = 1'b0;
    for (int unsigned i = 0; i < NBYP; i++) begin
      if (!hit && byp_we[i] && (byp_rc[5*i +: 5] == addr)) begin
        hit  = 1'b1;
        data = byp_data[XLEN*i +: XLEN];
        rdy  = byp_rdy[i];
      end
    end
    if (addr == 5'd31) begin
      data = '0;
      rdy  = 1'b1;
    end
    return {rdy, data};
  endfunction

  always_comb begin
    port1 = read_port(ra);
    port2 = read_port(addr2);
  end

  assign rd1  = port1[XLEN-1:0];
  assign rdy1 = port1[XLEN];
  assign rd2  = port2[XLEN-1:0];
  assign rdy2 = port2[XLEN];

  assign dec_stall     = valid_q && ((use1 && !rdy1) || (use2 && !rdy2));
  assign branch_target = pc_q + {lit_sxt[XLEN-3:0], 2'b00};

  always_comb begin
    br_taken  = 1'b0;
    br_target = branch_target;
    if (valid_q && !dec_stall && !flush) begin
      if (is_beq && (rd1 == '0)) begin
        br_taken = 1'b1;
      end else if (is_bne && (rd1 != '0)) begin
        br_taken = 1'b1;
      end else if (is_jmp) begin
        br_taken  = 1'b1;
        br_target = {rd1[XLEN-1:2], 2'b00};
      end
    end
  end

  always_comb begin
    ir_d       = ir_q;
    pc_d       = pc_q;
    valid_d    = valid_q;
    ex_valid_d = ex_valid_q;
    ex_inst_d  = ex_inst_q;
    ex_pc_d    = ex_pc_q;
    ex_a_d     = ex_a_q;
    ex_b_d     = ex_b_q;
    ex_st_d    = ex_st_q;
    if (flush) begin
      ir_d       = NOP_INST;
      valid_d    = 1'b0;
      ex_valid_d = 1'b0;
      ex_inst_d  = NOP_INST;
    end else if (exc_req) begin
      ex_inst_d  = EXC_INST;
      ex_valid_d = 1'b1;
      ex_pc_d    = pc_q;
      ir_d       = if_inst;
      pc_d       = if_pc4;
      valid_d    = if_valid;
    end else if (dec_stall) begin
      ex_inst_d  = NOP_INST;
      ex_valid_d = 1'b0;
    end else begin
      ex_valid_d = valid_q;
      ex_inst_d  = ir_q;
      ex_pc_d    = pc_q;
      ex_a_d     = is_ldr ? branch_target : rd1;
      ex_b_d     = (is_ld || is_st || is_opc) ? lit_sxt : rd2;
      ex_st_d    = rd2;
      pc_d       = if_pc4;
      // A taken branch annuls the successor fetched alongside it.
      if (br_taken) begin
        ir_d    = NOP_INST;
        valid_d = 1'b0;
      end else begin
        ir_d    = if_inst;
        valid_d = if_valid;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir_q       <= NOP_INST;
      pc_q       <= RESET_PC;
      valid_q    <= 1'b0;
      ex_valid_q <= 1'b0;
      ex_inst_q  <= NOP_INST;
      ex_pc_q    <= RESET_PC;
      ex_a_q     <= '0;
      ex_b_q     <= '0;
      ex_st_q    <= '0;
    end else begin
      ir_q       <= ir_d;
      pc_q       <= pc_d;
      valid_q    <= valid_d;
      ex_valid_q <= ex_valid_d;
      ex_inst_q  <= ex_inst_d;
      ex_pc_q    <= ex_pc_d;
      ex_a_q     <= ex_a_d;
      ex_b_q     <= ex_b_d;
      ex_st_q    <= ex_st_d;
    end
  end

  // Register file has no reset; R31 is never written and is forced to zero on read.
  always_ff @(posedge clk) begin
    if (wb_we && (wb_addr != 5'd31)) begin
      rf_q[wb_addr] <= wb_data;
    end
  end

  assign ex_valid = ex_valid_q;
  assign ex_inst  = ex_inst_q;
  assign ex_pc    = ex_pc_q;
  assign ex_a     = ex_a_q;
  assign ex_b     = ex_b_q;
  assign ex_st    = ex_st_q;

endmodule
